// File: rtl/alu_pkg.sv
// Shared definitions for the ALU self-test sequencer: op encodings, LFSR
// polynomial, FSM states and the LFSR step used for vector generation.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [31:0] LFSR_MASK   = 32'h8020_0003;
  localparam logic [15:0] NO_FAIL_IDX = 16'hFFFF;

  // Right-shifting Galois LFSR: the bit shifted out decides whether the taps are applied.
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    logic [31:0] n;
    n = l >> 1;
    if (l[0]) begin
      n = n ^ LFSR_MASK;
    end
    return n;
  endfunction

endpackage

// File: rtl/alu_selftest_seq_if.sv
// ALU operand/result bus; the self-test sequencer is the master, the ALU under test the slave.
interface alu_selftest_seq_if;
  import alu_pkg::*;

  logic [31:0] ALUA;
  logic [31:0] ALUB;
  logic [2:0]  ALUControl;
  logic [31:0] ALURe;
  logic        Zero;
  logic        mark;

  modport master (
    output ALUA,
    output ALUB,
    output ALUControl,
    input  ALURe,
    input  Zero,
    input  mark
  );

  modport slave (
    input  ALUA,
    input  ALUB,
    input  ALUControl,
    output ALURe,
    output Zero,
    output mark
  );

endinterface

// File: rtl/alu_golden.sv
// Combinational reference ALU: result, zero flag and signed-overflow flag
// for the eight single-cycle CPU operations.
module alu_golden
  import alu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_op,
  output logic [31:0] o_res,
  output logic        o_zero,
  output logic        o_ovf
);

  logic [31:0] w_sum;
  logic [31:0] w_diff;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;

  // Overflow only exists for ADD/SUB; every other op reports zero.
  always_comb begin
    o_res = 32'd0;
    o_ovf = 1'b0;
    case (alu_op_e'(i_op))
      ALU_ADD: begin
        o_res = w_sum;
        o_ovf = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
      end
      ALU_SUB: begin
        o_res = w_diff;
        o_ovf = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);
      end
      ALU_AND: o_res = i_a & i_b;
      ALU_OR:  o_res = i_a | i_b;
      ALU_XOR: o_res = i_a ^ i_b;
      ALU_SLL: o_res = i_a << i_b[4:0];
      ALU_SRL: o_res = i_a >> i_b[4:0];
      ALU_SLT: o_res = {31'd0, ($signed(i_a) < $signed(i_b))};
      default: o_res = 32'd0;
    endcase
    o_zero = (o_res == 32'd0);
  end

endmodule

// File: rtl/alu_selftest_seq.sv
// ALU bring-up sequencer: drives LFSR-generated vectors at one per cycle,
// checks each returned result against alu_golden and reports errors.
module alu_selftest_seq
  import alu_pkg::*;
#(
  parameter int          NUM_VECTORS = 16,
  parameter logic [31:0] SEED        = 32'hACE1_0001,
  parameter int          ERR_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  alu_selftest_seq_if.master alu,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [ERR_W-1:0]   o_err_count,
  output logic [15:0]        o_first_fail_idx
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [31:0]      SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [15:0]      LAST_IDX = 16'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_e           r_state;
  state_e           w_nextState;
  logic [31:0]      r_aluA;
  logic [31:0]      r_aluB;
  logic [2:0]       r_aluCtl;
  logic [31:0]      r_lfsr;
  logic [15:0]      r_idx;
  logic [ERR_W-1:0] r_errCount;
  logic [15:0]      r_firstFailIdx;

  logic             w_launch;
  logic             w_advance;
  logic [31:0]      w_srcLfsr;
  logic [31:0]      w_stepB;
  logic [31:0]      w_stepNext;
  logic [15:0]      w_nextIdx;
  logic [31:0]      w_goldRes;
  logic             w_goldZero;
  logic             w_goldOvf;
  logic             w_mismatch;

  alu_golden u_golden (
    .i_a    (r_aluA),
    .i_b    (r_aluB),
    .i_op   (r_aluCtl),
    .o_res  (w_goldRes),
    .o_zero (w_goldZero),
    .o_ovf  (w_goldOvf)
  );

  assign w_mismatch = ({alu.ALURe, alu.Zero, alu.mark} != {w_goldRes, w_goldZero, w_goldOvf});

  // A new run starts from the seed; otherwise generation continues from the held LFSR.
  assign w_srcLfsr  = w_launch ? SEED_EFF : r_lfsr;
  assign w_stepB    = lfsr_step(w_srcLfsr);
  assign w_stepNext = lfsr_step(w_stepB);
  assign w_nextIdx  = r_idx + 16'd1;

  always_comb begin
    w_nextState = r_state;
    w_launch    = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_launch    = 1'b1;
          w_nextState = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (r_idx == LAST_IDX) begin
          w_nextState = ST_DONE;
        end else begin
          w_advance = 1'b1;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Operand registers hold the last vector once the run reaches DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_aluA   <= 32'd0;
      r_aluB   <= 32'd0;
      r_aluCtl <= 3'd0;
      r_lfsr   <= SEED_EFF;
      r_idx    <= 16'd0;
    end else if (w_launch) begin
      r_aluA   <= SEED_EFF;
      r_aluB   <= w_stepB;
      r_aluCtl <= 3'd0;
      r_lfsr   <= w_stepNext;
      r_idx    <= 16'd0;
    end else if (w_advance) begin
      r_aluA   <= r_lfsr;
      r_aluB   <= w_stepB;
      r_aluCtl <= w_nextIdx[2:0];
      r_lfsr   <= w_stepNext;
      r_idx    <= w_nextIdx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_errCount     <= '0;
      r_firstFailIdx <= NO_FAIL_IDX;
    end else if (w_launch) begin
      r_errCount     <= '0;
      r_firstFailIdx <= NO_FAIL_IDX;
    end else if ((r_state == ST_CHECK) && w_mismatch) begin
      if (r_errCount != ERR_MAX) begin
        r_errCount <= r_errCount + 1'b1;
      end
      if (r_firstFailIdx == NO_FAIL_IDX) begin
        r_firstFailIdx <= r_idx;
      end
    end
  end

  assign alu.ALUA       = r_aluA;
  assign alu.ALUB       = r_aluB;
  assign alu.ALUControl = r_aluCtl;

  assign o_busy           = (r_state == ST_CHECK);
  assign o_done           = (r_state == ST_DONE);
  assign o_pass           = o_done && (r_errCount == '0);
  assign o_err_count      = r_errCount;
  assign o_first_fail_idx = r_firstFailIdx;

endmodule

// File: tb/tb_alu_selftest_seq.sv
// Bench for alu_selftest_seq: behavioural ALU with injectable faults, a vector
// model derived from the LFSR rules, and a per-cycle compare process.
module tb_alu_selftest_seq;

  localparam int          N    = 16;
  localparam int          N2   = 8;
  localparam logic [31:0] SEED = 32'hACE1_0001;
  localparam logic [31:0] MASK = 32'h8020_0003;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
  } aluOut_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic        start2;
  logic        busy, done, pass;
  logic [15:0] errCount, ffi;
  logic        busy2, done2, pass2;
  logic [1:0]  errCount2;
  logic [15:0] ffi2;
  int          faultMode;
  int          total = 0;
  int          bad = 0;

  logic [31:0] expA [N];
  logic [31:0] expB [N];
  logic [2:0]  expC [N];

  logic [31:0] gA, gB, gRes;
  logic [2:0]  gOp;
  logic        gZero, gOvf;

  alu_selftest_seq_if busIf ();
  alu_selftest_seq_if busIf2 ();

  alu_selftest_seq #(.NUM_VECTORS(N), .SEED(SEED), .ERR_W(16)) u_dut (
    .clk              (clk),
    .reset            (reset),
    .i_start          (start),
    .alu              (busIf),
    .o_busy           (busy),
    .o_done           (done),
    .o_pass           (pass),
    .o_err_count      (errCount),
    .o_first_fail_idx (ffi)
  );

  alu_selftest_seq #(.NUM_VECTORS(N2), .SEED(SEED), .ERR_W(2)) u_dutSat (
    .clk              (clk),
    .reset            (reset),
    .i_start          (start2),
    .alu              (busIf2),
    .o_busy           (busy2),
    .o_done           (done2),
    .o_pass           (pass2),
    .o_err_count      (errCount2),
    .o_first_fail_idx (ffi2)
  );

  alu_golden u_gold (
    .i_a    (gA),
    .i_b    (gB),
    .i_op   (gOp),
    .o_res  (gRes),
    .o_zero (gZero),
    .o_ovf  (gOvf)
  );

  function automatic logic [31:0] lfsrNext(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? MASK : 32'd0);
  endfunction

  // Overflow is judged by whether the exact 64-bit result survives truncation to 32 bits.
  function automatic aluOut_t refAlu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    aluOut_t o;
    longint  sa, sb, exact;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    exact = 0;
    o     = '0;
    case (op)
      3'd0: begin exact = sa + sb; o.res = exact[31:0]; o.ovf = (exact != longint'($signed(o.res))); end
      3'd1: begin exact = sa - sb; o.res = exact[31:0]; o.ovf = (exact != longint'($signed(o.res))); end
      3'd2: o.res = a & b;
      3'd3: o.res = a | b;
      3'd4: o.res = a ^ b;
      3'd5: o.res = a << b[4:0];
      3'd6: o.res = a >> b[4:0];
      default: o.res = (sa < sb) ? 32'd1 : 32'd0;
    endcase
    o.zero = (o.res == 32'd0);
    return o;
  endfunction

  function automatic aluOut_t applyFault(input aluOut_t t, input int mode);
    aluOut_t f;
    f = t;
    if (mode == 1) f.res[0] = 1'b0;
    if (mode == 2) f.res = ~t.res;
    return f;
  endfunction

  always_comb begin : aluModel
    aluOut_t t;
    t = applyFault(refAlu(busIf.ALUA, busIf.ALUB, busIf.ALUControl), faultMode);
    busIf.ALURe = t.res;
    busIf.Zero  = t.zero;
    busIf.mark  = t.ovf;
  end

  always_comb begin : aluModelInv
    aluOut_t t;
    t = applyFault(refAlu(busIf2.ALUA, busIf2.ALUB, busIf2.ALUControl), 2);
    busIf2.ALURe = t.res;
    busIf2.Zero  = t.zero;
    busIf2.mark  = t.ovf;
  end

  task automatic buildVectors();
    logic [31:0] l;
    l = (SEED == 32'd0) ? 32'd1 : SEED;
    for (int i = 0; i < N; i++) begin
      expA[i] = l;
      expB[i] = lfsrNext(l);
      expC[i] = 3'(i % 8);
      l = lfsrNext(expB[i]);
    end
  endtask

  task automatic expectRun(input int mode, input int n, input int maxErr, output int err, output int firstIdx);
    aluOut_t t;
    err = 0;
    firstIdx = 65535;
    for (int i = 0; i < n; i++) begin
      t = refAlu(expA[i], expB[i], expC[i]);
      if (applyFault(t, mode) != t) begin
        if (err < maxErr) err++;
        if (firstIdx == 65535) firstIdx = i;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulses start, then counts busy cycles until done; optionally injects a start or a reset mid-run.
  task automatic applyStimulus(input int injectAt, input bit injectReset, output int cnt, output bit finished);
    cnt = 0;
    finished = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (done) begin
        finished = 1'b1;
        break;
      end
      if (busy) cnt++;
      if (busy && (cnt == injectAt)) begin
        if (injectReset) begin
          reset = 1'b1;
          return;
        end
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // Every busy cycle must present the next model vector; DONE must hold the last one.
  initial begin : compareProc
    int   chkIdx;
    logic prevBusy;
    chkIdx = 0;
    prevBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy && !prevBusy) chkIdx = 0;
      if (busy) begin
        if (chkIdx < N) begin
          checkOutput("vecA", busIf.ALUA, expA[chkIdx]);
          checkOutput("vecB", busIf.ALUB, expB[chkIdx]);
          checkOutput("vecCtl", busIf.ALUControl, expC[chkIdx]);
        end else begin
          checkOutput("extraCheckCycle", 64'(chkIdx), 64'(N - 1));
        end
        chkIdx++;
      end else if (done) begin
        checkOutput("holdA", busIf.ALUA, expA[N-1]);
        checkOutput("holdCtl", busIf.ALUControl, expC[N-1]);
      end
      prevBusy = busy;
    end
  end

  initial begin : mainProc
    int cnt;
    bit fin;
    int eErr, eFfi;

    reset = 1'b1; start = 1'b0; start2 = 1'b0; faultMode = 0;
    gA = 32'd0; gB = 32'd0; gOp = 3'd0;
    buildVectors();
    repeat (3) @(negedge clk);

    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstPass", pass, 0);
    checkOutput("rstA", busIf.ALUA, 0);
    checkOutput("rstB", busIf.ALUB, 0);
    checkOutput("rstCtl", busIf.ALUControl, 0);
    checkOutput("rstErr", errCount, 0);
    checkOutput("rstFfi", ffi, 16'hFFFF);
    checkOutput("rstFfi2", ffi2, 16'hFFFF);
    reset = 1'b0;

    checkOutput("pinLfsr", lfsrNext(32'hACE1_0001), 32'hD650_8003);
    checkOutput("pinModelAdd", refAlu(32'h7FFF_FFFF, 32'd1, 3'd0), {32'h8000_0000, 1'b0, 1'b1});
    checkOutput("pinModelSlt", refAlu(32'hFFFF_FFFF, 32'd1, 3'd7), {32'd1, 1'b0, 1'b0});

    gA = 32'hFFFF_0000; gB = 32'd16; gOp = 3'd3; #1;
    checkOutput("goldOrRes", gRes, 32'hFFFF_0010);
    checkOutput("goldOrZero", gZero, 0);
    gOp = 3'd6; #1;
    checkOutput("goldSrlRes", gRes, 32'h0000_FFFF);
    gA = 32'h7FFF_FFFF; gB = 32'd1; gOp = 3'd0; #1;
    checkOutput("goldAddRes", gRes, 32'h8000_0000);
    checkOutput("goldAddOvf", gOvf, 1);

    $display("[TB] run 1: correct ALU");
    applyStimulus(-1, 1'b0, cnt, fin);
    checkOutput("run1Finished", fin, 1);
    checkOutput("run1BusyCycles", cnt, N);
    checkOutput("run1Pass", pass, 1);
    checkOutput("run1Err", errCount, 0);
    checkOutput("run1Ffi", ffi, 16'hFFFF);

    $display("[TB] run 2: ALURe[0] stuck at 0");
    faultMode = 1;
    expectRun(1, N, 65535, eErr, eFfi);
    applyStimulus(-1, 1'b0, cnt, fin);
    checkOutput("run2Finished", fin, 1);
    checkOutput("run2Pass", pass, 0);
    checkOutput("run2ErrNonZero", (errCount != 16'd0), 1);
    checkOutput("run2Err", errCount, eErr);
    checkOutput("run2Ffi", ffi, eFfi);

    $display("[TB] run 3: start ignored during CHECK");
    faultMode = 0;
    applyStimulus(3, 1'b0, cnt, fin);
    checkOutput("run3Finished", fin, 1);
    checkOutput("run3BusyCycles", cnt, N);
    checkOutput("run3Pass", pass, 1);

    $display("[TB] run 4: restart from DONE");
    applyStimulus(-1, 1'b0, cnt, fin);
    checkOutput("run4BusyCycles", cnt, N);
    checkOutput("run4Pass", pass, 1);
    checkOutput("run4Ffi", ffi, 16'hFFFF);

    $display("[TB] run 5: reset mid-run");
    faultMode = 2;
    applyStimulus(8, 1'b1, cnt, fin);
    checkOutput("run5CyclesBeforeReset", cnt, 8);
    @(negedge clk);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDone", done, 0);
    checkOutput("abortA", busIf.ALUA, 0);
    checkOutput("abortErr", errCount, 0);
    checkOutput("abortFfi", ffi, 16'hFFFF);
    reset = 1'b0;
    faultMode = 0;

    $display("[TB] run 6: saturating counter, inverted ALU");
    expectRun(2, N2, 3, eErr, eFfi);
    checkOutput("satModelErr", eErr, 3);
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (done2) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("satFinished", fin, 1);
    checkOutput("satErr", errCount2, eErr);
    checkOutput("satFfi", ffi2, eFfi);
    checkOutput("satPass", pass2, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
